// File: rtl/compression_stream_scheduler_if.sv
// Bundle of the requester, core-input, core-output and per-stream return AXI4-Stream channels.
// Every channel transfers a beat on a rising edge where tvalid and tready are both 1; tready may depend combinationally on tvalid, and tvalid must not depend on tready.
interface compression_stream_scheduler_if #(
   parameter int N_STREAMS = 4,
   parameter int DATA_W    = 64
);
   localparam int KEEP_W = DATA_W / 8;

   logic [N_STREAMS*DATA_W-1:0] s_tdata;
   logic [N_STREAMS*KEEP_W-1:0] s_tkeep;
   logic [N_STREAMS-1:0]        s_tlast;
   logic [N_STREAMS-1:0]        s_tvalid;
   logic [N_STREAMS-1:0]        s_tready;

   logic [DATA_W-1:0]           c_tdata;
   logic [KEEP_W-1:0]           c_tkeep;
   logic                        c_tlast;
   logic                        c_tvalid;
   logic                        c_tready;

   logic [DATA_W-1:0]           r_tdata;
   logic [KEEP_W-1:0]           r_tkeep;
   logic                        r_tlast;
   logic                        r_tvalid;
   logic                        r_tready;

   logic [N_STREAMS*DATA_W-1:0] m_tdata;
   logic [N_STREAMS*KEEP_W-1:0] m_tkeep;
   logic [N_STREAMS-1:0]        m_tlast;
   logic [N_STREAMS-1:0]        m_tvalid;
   logic [N_STREAMS-1:0]        m_tready;

   // Scheduler side.
   modport slave (
      input  s_tdata, s_tkeep, s_tlast, s_tvalid,
      output s_tready,
      output c_tdata, c_tkeep, c_tlast, c_tvalid,
      input  c_tready,
      input  r_tdata, r_tkeep, r_tlast, r_tvalid,
      output r_tready,
      output m_tdata, m_tkeep, m_tlast, m_tvalid,
      input  m_tready
   );

   // Requesters, core and consumers.
   modport master (
      output s_tdata, s_tkeep, s_tlast, s_tvalid,
      input  s_tready,
      input  c_tdata, c_tkeep, c_tlast, c_tvalid,
      output c_tready,
      output r_tdata, r_tkeep, r_tlast, r_tvalid,
      input  r_tready,
      input  m_tdata, m_tkeep, m_tlast, m_tvalid,
      output m_tready
   );
endinterface

// File: rtl/compression_stream_scheduler.sv
// Packet-granular round-robin sharing of one in-order compression core between N_STREAMS requesters.
// A grant-order tag FIFO steers each returned packet back to the stream that sent it.
module compression_stream_scheduler #(
   parameter int N_STREAMS = 4,
   parameter int DATA_W    = 64,
   parameter int TAG_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   compression_stream_scheduler_if.slave bus,
   output logic [$clog2(TAG_DEPTH):0]   inflight,
   output logic                         dbg_state,
   output logic [$clog2(N_STREAMS)-1:0] dbg_rr_ptr,
   output logic [$clog2(N_STREAMS)-1:0] dbg_grant
);
   localparam int PTR_W  = $clog2(N_STREAMS);
   localparam int KEEP_W = DATA_W / 8;
   localparam int AW     = $clog2(TAG_DEPTH);
   localparam int CNT_W  = AW + 1;

   typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

   state_t           state, state_next;
   logic [PTR_W-1:0] rr_ptr, grant, winner, head;
   logic             found, fifo_full, fifo_empty;
   logic             grant_fire, pkt_done, ret_pop;

   logic [PTR_W-1:0] tag_mem [TAG_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;

   assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
   assign fifo_empty = (count == '0);
   assign head       = tag_mem[rd_ptr];

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin : arbiter_scan
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < N_STREAMS; k++) begin
         idx = (int'(rr_ptr) + k) % N_STREAMS;
         if (!found && bus.s_tvalid[idx]) begin
            found  = 1'b1;
            winner = PTR_W'(idx);
         end
      end
   end

   assign grant_fire = (state == IDLE) && found && !fifo_full;
   assign pkt_done   = (state == PASS) && bus.c_tvalid && bus.c_tready && bus.c_tlast;
   assign ret_pop    = !fifo_empty && bus.r_tvalid && bus.r_tready && bus.r_tlast;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_fire) state_next = PASS;
         PASS:    if (pkt_done)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Forward path: a plain mux onto the granted stream; IDLE is the one-cycle bubble between packets.
   always_comb begin
      bus.c_tdata  = bus.s_tdata[grant*DATA_W +: DATA_W];
      bus.c_tkeep  = bus.s_tkeep[grant*KEEP_W +: KEEP_W];
      bus.c_tlast  = 1'b0;
      bus.c_tvalid = 1'b0;
      bus.s_tready = '0;
      if (state == PASS) begin
         bus.c_tlast         = bus.s_tlast[grant];
         bus.c_tvalid        = bus.s_tvalid[grant];
         bus.s_tready[grant] = bus.c_tready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         if (grant_fire) grant  <= winner;
         if (pkt_done)   rr_ptr <= PTR_W'((int'(grant) + 1) % N_STREAMS);
      end
   end

   always_ff @(posedge clk) begin
      if (grant_fire) tag_mem[wr_ptr] <= winner;
   end

   // Simultaneous grant and return pop leave the occupancy unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (grant_fire) wr_ptr <= wr_ptr + 1'b1;
         if (ret_pop)    rd_ptr <= rd_ptr + 1'b1;
         if (grant_fire && !ret_pop)      count <= count + 1'b1;
         else if (!grant_fire && ret_pop) count <= count - 1'b1;
      end
   end

   // Return path: data is broadcast, only the head tag's stream sees valid.
   always_comb begin
      bus.m_tdata  = {N_STREAMS{bus.r_tdata}};
      bus.m_tkeep  = {N_STREAMS{bus.r_tkeep}};
      bus.m_tvalid = '0;
      bus.m_tlast  = '0;
      bus.r_tready = 1'b0;
      if (!fifo_empty) begin
         bus.m_tvalid[head] = bus.r_tvalid;
         bus.m_tlast[head]  = bus.r_tlast;
         bus.r_tready       = bus.m_tready[head];
      end
   end

   assign inflight   = count;
   assign dbg_state  = (state == PASS);
   assign dbg_rr_ptr = rr_ptr;
   assign dbg_grant  = grant;
endmodule
